serial_subtractor_4bit: RTL and testbench
=========================================

// Module: serial_subtractor_4bit
// PURPOSE
//  Bit-serial 4-bit subtractor: computes D = A - B - Bin one bit per clock, LSB first.
//  Uses a single full-subtractor cell plus a small FSM.
//  Sequential, single-cell counterpart of the ripple adder lab; A, B and Bin come from switches,
//  result and status go to LEDs.
//  Start is a KEY press; the result is held until the next press.
// PARAMETERS
//  WIDTH        4  operand width in bits; the board mapping supports only 4
//  SYNC_STAGES  2  flip-flop stages in the start-button synchroniser (>=2)
// PORTS
//  CLOCK_50  in   1   system clock; all state changes on rising edge
//  KEY       in   2   KEY[0] = reset: asynchronous, active-low; KEY[1] = start: active-low, asynchronous to clock
//  SW        in   10  SW[3:0] = A, SW[7:4] = B, SW[9] = Bin; SW[8] unused
//  LEDR      out  10  LEDR[3:0] = D, LEDR[5:4] = 0, LEDR[6] = overflow, LEDR[7] = done,
//                     LEDR[8] = busy, LEDR[9] = borrow out
// BEHAVIOUR
//  - Reset (KEY[0]=0): immediate and asynchronous, from any state including mid-SHIFT.
//    Effects: state=IDLE; all LEDR=0; shift regs, bit counter and borrow reg = 0.
//  - Start: KEY[1] passes through SYNC_STAGES synchroniser flops.
//    start_pulse = one-cycle pulse on the synchronised 1->0 edge. Holding the key gives one pulse only.
//  - FSM states: IDLE, LOAD, SHIFT, DONE.
//    IDLE  --start_pulse--> LOAD
//    LOAD  (1 cycle) latches a_sr=SW[3:0], b_sr=SW[7:4], borrow=SW[9];
//          clears D, done, overflow, borrow out; sets busy; -> SHIFT
//    SHIFT runs exactly WIDTH cycles. Each cycle:
//          d_bit from cell(a_sr[0], b_sr[0], borrow) is shifted into result MSB;
//          a_sr and b_sr shift right; borrow <= cell bout; counter increments.
//          After the WIDTH-th bit -> DONE.
//    DONE  LEDR[3:0] = result; LEDR[9] = final borrow; done=1; busy=0.
//          Held until start_pulse -> LOAD (new operation).
//  - Latency: done rises WIDTH+2 clocks after the start_pulse cycle (6 for WIDTH=4).
//    busy is high during LOAD and SHIFT only.
//  - start_pulse during LOAD or SHIFT is ignored (no restart, no queueing).
//  - SW changes after LOAD do not affect the current result.
//  - Arithmetic: D = (A - B - Bin) mod 2^WIDTH; borrow out = 1 iff A < B + Bin (unsigned).
//  - All LEDR are driven from registers; no combinational path from SW to LEDR.
// CONFIGURATION
//  - SERIAL_SUB_OVERFLOW_EN defined:
//    LEDR[6] = two's-complement overflow, registered on the SHIFT->DONE transition.
//    Formula: (A[3]!=B[3]) && (D[3]!=A[3]), using latched A and B; cleared in LOAD and on reset.
//  - SERIAL_SUB_OVERFLOW_EN not defined: LEDR[6] is tied to 0 and no overflow logic exists.
// STRUCTURE
//  - Shared header ps1_defs.vh holds:
//    FSM state encodings (ST_IDLE=2'd0, ST_LOAD=2'd1, ST_SHIFT=2'd2, ST_DONE=2'd3);
//    LEDR bit indices (LED_OVF=6, LED_DONE=7, LED_BUSY=8, LED_BOUT=9).
//  - One sub-module: full_subtractor_1_bit(a, b, bin, d, bout), gate-level.
//    d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
//    Instantiated once. Synchroniser, edge detect, FSM and datapath are in the top.
// TESTING
//  1. Assert KEY[0]=0 mid-SHIFT -> LEDR==0 immediately; FSM in IDLE. After release, no activity until start.
//  2. A=9, B=3, Bin=0, press start -> 6 clocks later LEDR[3:0]=6, borrow=0, done=1, busy=0.
//     With macro, overflow=1 (-7-3).
//  3. A=3, B=9, Bin=0 -> D=4'hA, borrow=1. With macro, overflow=1. Without macro, LEDR[6]=0.
//  4. A=0, B=0, Bin=1 -> D=4'hF, borrow=1, overflow=0.
//     A=5, B=5, Bin=0 -> D=0, borrow=0.
//  5. Press start again during SHIFT and toggle SW during SHIFT -> result unchanged from the first operation;
//     busy pulse length stays WIDTH+1 clocks.
//  6. Hold KEY[1] low for 100 clocks -> exactly one operation.
//     Release and press again in DONE -> LOAD clears done and D, then the new result appears.

Source files
------------

// File: rtl/serial_subtractor_4bit_pkg.sv
// rtl/serial_subtractor_4bit_pkg.sv - shared constants and types for the serial subtractor
// Holds the FSM state encoding, LEDR bit positions, default sizes and the
// start-key edge helper used by serial_subtractor_4bit.
package serial_subtractor_4bit_pkg;

   localparam int WIDTH_DEF       = 4;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int LED_OVF  = 6;
   localparam int LED_DONE = 7;
   localparam int LED_BUSY = 8;
   localparam int LED_BOUT = 9;

   // KEY[1] is active-low, so a press is a 1->0 transition.
   function automatic logic press_edge(input logic prev, input logic cur);
      return prev & ~cur;
   endfunction

endpackage

// File: rtl/serial_subtractor_4bit_full_subtractor.sv
// rtl/serial_subtractor_4bit_full_subtractor.sv - gate-level one-bit full subtractor cell
// Ports: a, b   operand bits
//        bin    borrow in
//        d      difference bit  (a - b - bin)
//        bout   borrow out
module full_subtractor_1_bit
   import serial_subtractor_4bit_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic a_xor_b;

   assign a_xor_b = a ^ b;
   assign d       = a_xor_b ^ bin;
   assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// rtl/serial_subtractor_4bit.sv - bit-serial subtractor D = A - B - Bin, LSB first
// Ports: CLOCK_50      system clock, rising edge
//        KEY[0]        asynchronous active-low reset
//        KEY[1]        start, active-low, asynchronous to CLOCK_50
//        SW[3:0] = A, SW[7:4] = B, SW[9] = Bin, SW[8] unused
//        LEDR[3:0] = D, LEDR[6] = overflow, LEDR[7] = done,
//        LEDR[8] = busy, LEDR[9] = borrow out, LEDR[5:4] = 0
// Optional feature: define SERIAL_SUB_OVERFLOW_EN for two's-complement overflow on LEDR[6].
module serial_subtractor_4bit
   import serial_subtractor_4bit_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
)
(
   input  logic       CLOCK_50,
   input  logic [1:0] KEY,
   input  logic [9:0] SW,
   output logic [9:0] LEDR
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic rst_n;
   assign rst_n = KEY[0];

   logic unused_sw;
   assign unused_sw = SW[8];

   // Start synchroniser; flops idle at 1 (key released) so reset release
   // never looks like a press.
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   key_prev_q;
   logic                   start_pulse;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '1;
         key_prev_q <= 1'b1;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], KEY[1]};
         key_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign start_pulse = press_edge(key_prev_q, sync_q[SYNC_STAGES-1]);

   // FSM
   state_t state_q, state_d;
   logic   enter_load;
   logic   shift_en;
   logic   finish;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      enter_load = 1'b0;
      shift_en   = 1'b0;
      finish     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_pulse) begin
               state_d    = ST_LOAD;
               enter_load = 1'b1;
            end
         end
         ST_LOAD: state_d = ST_SHIFT;
         ST_SHIFT: begin
            shift_en = 1'b1;
            if (cnt_q == LAST_BIT) begin
               state_d = ST_DONE;
               finish  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: operands are captured on the way into LOAD, so later SW
   // activity cannot reach the running operation.
   logic [WIDTH-1:0] a_sr_q, b_sr_q, res_q, d_q;
   logic             borrow_q, bout_q, done_q, busy_q;
   logic             d_bit, bout_bit;
   logic [WIDTH-1:0] res_next;

   full_subtractor_1_bit u_cell (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .bin  (borrow_q),
      .d    (d_bit),
      .bout (bout_bit)
   );

   assign res_next = {d_bit, res_q[WIDTH-1:1]};

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_q    <= '0;
         d_q      <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
      end else if (enter_load) begin
         a_sr_q   <= SW[WIDTH-1:0];
         b_sr_q   <= SW[4 +: WIDTH];
         borrow_q <= SW[9];
         res_q    <= '0;
         d_q      <= '0;
         bout_q   <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b1;
         cnt_q    <= '0;
      end else if (shift_en) begin
         res_q    <= res_next;
         a_sr_q   <= a_sr_q >> 1;
         b_sr_q   <= b_sr_q >> 1;
         borrow_q <= bout_bit;
         cnt_q    <= cnt_q + 1'b1;
         if (finish) begin
            d_q    <= res_next;
            bout_q <= bout_bit;
            done_q <= 1'b1;
            busy_q <= 1'b0;
         end
      end
   end

   logic ovf_led;

`ifdef SERIAL_SUB_OVERFLOW_EN
   // Operand sign bits are kept separately because the shift registers
   // have been emptied by the time the result is complete.
   logic a_msb_q, b_msb_q, ovf_q;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (enter_load) begin
         a_msb_q <= SW[WIDTH-1];
         b_msb_q <= SW[4 + WIDTH - 1];
         ovf_q   <= 1'b0;
      end else if (finish) begin
         // d_bit is the result MSB on the final shift.
         ovf_q   <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
      end
   end

   assign ovf_led = ovf_q;
`else
   assign ovf_led = 1'b0;
`endif

   always_comb begin
      LEDR              = '0;
      LEDR[WIDTH-1:0]   = d_q;
      LEDR[LED_OVF]     = ovf_led;
      LEDR[LED_DONE]    = done_q;
      LEDR[LED_BUSY]    = busy_q;
      LEDR[LED_BOUT]    = bout_q;
   end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// tb/tb_serial_subtractor_4bit.sv - randomized self-checking bench for serial_subtractor_4bit
module tb_serial_subtractor_4bit;

`ifdef SERIAL_SUB_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic       CLOCK_50 = 1'b0;
   logic [1:0] KEY;
   logic [9:0] SW;
   logic [9:0] LEDR;

   int n_vec = 0;
   int n_err = 0;

   serial_subtractor_4bit dut (
      .CLOCK_50 (CLOCK_50),
      .KEY      (KEY),
      .SW       (SW),
      .LEDR     (LEDR)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: {overflow, borrow_out, D} from plain integer arithmetic.
   function automatic logic [5:0] ref_sub(input logic [3:0] a, input logic [3:0] b, input logic bin);
      int ua, ub, bi, u, sa, sb, s;
      logic [3:0] d;
      logic ovf;
      ua  = a;
      ub  = b;
      bi  = bin;
      u   = ua - ub - bi;
      d   = 4'(u & 15);
      sa  = (ua > 7) ? ua - 16 : ua;
      sb  = (ub > 7) ? ub - 16 : ub;
      s   = sa - sb - bi;
      ovf = OVF_EN && ((s > 7) || (s < -8));
      return {ovf, (u < 0), d};
   endfunction

   // mode 0: plain op; 1: re-press and scramble SW during SHIFT; 2: hold key 100 clocks after done
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin, input int mode);
      int t, t_busy, n_busy, t_done, extra_busy;
      logic [5:0] e;
      logic [9:0] exp_led;
      e       = ref_sub(a, b, bin);
      exp_led = {e[4], 1'b0, 1'b1, e[5], 2'b00, e[3:0]};
      SW      = {bin, 1'b0, b, a};
      KEY[1]  = 1'b0;
      t = 0; t_busy = -1; n_busy = 0; t_done = -1;
      while (t < 40 && t_done < 0) begin
         @(negedge CLOCK_50);
         t++;
         if (LEDR[8]) begin
            n_busy++;
            if (t_busy < 0) begin
               t_busy = t;
               chk("load_clears", 32'({LEDR[7], LEDR[3:0]}), 32'd0);
            end
         end
         if (t_busy >= 0 && LEDR[7]) t_done = t;
         if (mode == 1 && t == 3) KEY[1] = 1'b1;
         if (mode == 1 && t == 4) begin
            KEY[1] = 1'b0;
            SW     = 10'($urandom);
         end
      end
      chk("busy_latency", 32'(t_busy), 32'd3);
      chk("done_latency", 32'(t_done), 32'd8);
      chk("busy_length",  32'(n_busy), 32'd5);
      chk("diff",         32'(LEDR[3:0]), 32'(e[3:0]));
      chk("borrow_out",   32'(LEDR[9]), 32'(e[4]));
      chk("overflow",     32'(LEDR[6]), 32'(e[5]));
      chk("zero_pad",     32'(LEDR[5:4]), 32'd0);
      chk("busy_in_done", 32'(LEDR[8]), 32'd0);
      if (mode == 2) begin
         extra_busy = 0;
         repeat (100) begin
            @(negedge CLOCK_50);
            if (LEDR[8]) extra_busy++;
         end
         chk("hold_one_op", 32'(extra_busy), 32'd0);
      end
      KEY[1] = 1'b1;
      repeat (4) @(negedge CLOCK_50);
      chk("result_held", 32'(LEDR), 32'(exp_led));
   endtask

   task automatic reset_mid_shift();
      logic [9:0] acc;
      SW     = {1'b0, 1'b0, 4'd3, 4'd9};
      KEY[1] = 1'b0;
      repeat (5) @(negedge CLOCK_50);
      chk("busy_before_rst", 32'(LEDR[8]), 32'd1);
      #3 KEY = 2'b10;
      #1 chk("async_reset", 32'(LEDR), 32'd0);
      @(negedge CLOCK_50);
      KEY = 2'b11;
      acc = '0;
      repeat (10) begin
         @(negedge CLOCK_50);
         acc |= LEDR;
      end
      chk("idle_after_rst", 32'(acc), 32'd0);
   endtask

   initial begin
      KEY = 2'b00;
      SW  = '0;
      repeat (3) @(negedge CLOCK_50);
      chk("reset_state", 32'(LEDR), 32'd0);
      KEY = 2'b11;
      repeat (4) @(negedge CLOCK_50);
      chk("idle_state", 32'(LEDR), 32'd0);

      run_op(4'd9, 4'd3, 1'b0, 0);
      run_op(4'd3, 4'd9, 1'b0, 0);
      run_op(4'd0, 4'd0, 1'b1, 0);
      run_op(4'd5, 4'd5, 1'b0, 0);
      reset_mid_shift();
      run_op(4'd9, 4'd3, 1'b0, 0);
      run_op(4'd12, 4'd7, 1'b1, 1);
      run_op(4'd6, 4'd11, 1'b0, 2);
      run_op(4'd14, 4'd2, 1'b1, 0);
      run_op(4'd15, 4'd15, 1'b1, 0);
      run_op(4'd0, 4'd15, 1'b1, 0);
      run_op(4'd8, 4'd0, 1'b1, 0);
      run_op(4'd7, 4'd15, 1'b0, 0);
      for (int i = 0; i < 20; i++) begin
         run_op(4'($urandom), 4'($urandom), 1'($urandom), (i % 5 == 4) ? 1 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
